cu_fsm_irq: RTL and testbench

Parametrised multicycle control-unit FSM for the OTTER MCU, successor to the basic fetch/execute/writeback controller. It sequences fetch, execute and load writeback with configurable memory latencies. It decodes SYSTEM instructions (CSR write, mret) and takes prioritised, maskable interrupts between instructions. It sits between the instruction register / CSR file and the PC, register file, memory and CSR write enables.

---
 rtl/cu_fsm_irq_pkg.sv | 39 +++
 rtl/cu_fsm_irq_if.sv | 39 +++
 rtl/cu_fsm_irq_int_prio_enc.sv | 35 +++
 rtl/cu_fsm_irq.sv | 154 +++++++++++++++
 tb/tb_cu_fsm_irq.sv | 126 ++++++++++++
 5 files changed

// File: rtl/cu_fsm_irq_pkg.sv
// Shared types and helpers for the multicycle OTTER control unit with interrupt entry.
// Holds the opcode/state enumerations and the width calculations used by the FSM.
package cu_fsm_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    localparam logic [2:0] FUNCT3_PRIV = 3'b000;

    function automatic int calc_idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter must reach max(FETCH_LAT, LOAD_LAT) - 1; one spare code keeps width >= 1.
    function automatic int calc_cw(input int f, input int l);
        int m;
        m = (f > l) ? f : l;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cu_fsm_irq_if.sv
// Instruction-field, interrupt and write-enable bundle between the control unit
// (master) and the datapath / CSR file (slave).
interface cu_fsm_irq_if
    import cu_fsm_pkg::*;
#(
    parameter int NUM_INT = 1
);
    localparam int IDW = calc_idw(NUM_INT);

    logic [6:0]         ir6_0;
    logic [2:0]         ir14_12;
    logic [NUM_INT-1:0] intr;
    logic               int_en;

    logic               PCWrite;
    logic               regWrite;
    logic               memWE2;
    logic               memRDEN1;
    logic               memRDEN2;
    logic               reset;
    logic               csr_WE;
    logic               int_taken;
    logic               mret_exec;
    logic [IDW-1:0]     int_id;
    logic               illegal;

    modport master (
        input  ir6_0, ir14_12, intr, int_en,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
               csr_WE, int_taken, mret_exec, int_id, illegal
    );

    modport slave (
        output ir6_0, ir14_12, intr, int_en,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
               csr_WE, int_taken, mret_exec, int_id, illegal
    );

endinterface

// File: rtl/cu_fsm_irq_int_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module int_prio_enc #(
    parameter int NUM_INT = 1,
    parameter int IDW     = 1
) (
    input  logic [NUM_INT-1:0] req,
    output logic [IDW-1:0]     idx,
    output logic               valid
);

    logic [NUM_INT-1:0] hit;

    // hit is one-hot: a line wins only if every lower-index line is idle.
    generate
        for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_hit
            if (gi == 0) begin : g_first
                assign hit[gi] = req[gi];
            end else begin : g_rest
                assign hit[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (hit[i]) begin
                idx = idx | IDW'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/cu_fsm_irq.sv
// Multicycle control-unit FSM: fetch / execute / load writeback with configurable
// latencies, SYSTEM decode (CSR write, mret) and interrupt entry between instructions.
module cu_fsm_irq
    import cu_fsm_pkg::*;
#(
    parameter int NUM_INT   = 1,
    parameter int FETCH_LAT = 1,
    parameter int LOAD_LAT  = 1
) (
    input  logic         CLK,
    input  logic         RST,
    cu_fsm_irq_if.master bus
);

    localparam int IDW = calc_idw(NUM_INT);
    localparam int CW  = calc_cw(FETCH_LAT, LOAD_LAT);
    localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_LAT - 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_LAT - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [IDW-1:0] prio_idx;
    logic           prio_valid;
    logic           pend;
    logic           done;

    logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, pc_reset;
    logic csr_we, int_taken, mret_exec, illegal;
    logic [IDW-1:0] int_id;

    int_prio_enc #(
        .NUM_INT (NUM_INT),
        .IDW     (IDW)
    ) u_prio (
        .req   (bus.intr),
        .idx   (prio_idx),
        .valid (prio_valid)
    );

    assign pend = bus.int_en & prio_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_we2    = 1'b0;
        mem_rden1  = 1'b0;
        mem_rden2  = 1'b0;
        pc_reset   = 1'b0;
        csr_we     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        illegal    = 1'b0;
        int_id     = '0;

        case (state_reg)
            ST_INIT: begin
                pc_reset   = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (cnt_reg == FETCH_LAST) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                done = 1'b1;
                case (bus.ir6_0)
                    LOAD: begin
                        mem_rden2  = 1'b1;
                        done       = 1'b0;
                        state_next = ST_WB;
                    end
                    OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                    end
                    STORE: begin
                        pc_write = 1'b1;
                        mem_we2  = 1'b1;
                    end
                    BRANCH: begin
                        pc_write = 1'b1;
                    end
                    SYSTEM: begin
                        pc_write = 1'b1;
                        if (bus.ir14_12 == FUNCT3_PRIV) begin
                            mret_exec = 1'b1;
                        end else begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcode: step past it without touching any state.
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                if (cnt_reg == LOAD_LAST) begin
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    done      = 1'b1;
                end else begin
                    mem_rden2 = 1'b1;
                end
            end
            ST_INTR: begin
                int_taken  = 1'b1;
                pc_write   = 1'b1;
                int_id     = prio_idx;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // Interrupts are only sampled at an instruction boundary.
        if (done) begin
            state_next = pend ? ST_INTR : ST_FETCH;
        end
    end

    assign cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CW'(1);

    assign bus.PCWrite   = pc_write;
    assign bus.regWrite  = reg_write;
    assign bus.memWE2    = mem_we2;
    assign bus.memRDEN1  = mem_rden1;
    assign bus.memRDEN2  = mem_rden2;
    assign bus.reset     = pc_reset;
    assign bus.csr_WE    = csr_we;
    assign bus.int_taken = int_taken;
    assign bus.mret_exec = mret_exec;
    assign bus.int_id    = int_id;
    assign bus.illegal   = illegal;

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Directed bench: dut_a (NUM_INT=4, unit latencies) runs mixed instructions and
// interrupts; dut_b (NUM_INT=1, FETCH_LAT=3, LOAD_LAT=2) runs back-to-back loads.
module tb_cu_fsm_irq;
    import cu_fsm_pkg::*;

    localparam logic [9:0] PCW  = 10'h200;
    localparam logic [9:0] RW   = 10'h100;
    localparam logic [9:0] WE2  = 10'h080;
    localparam logic [9:0] RD1  = 10'h040;
    localparam logic [9:0] RD2  = 10'h020;
    localparam logic [9:0] RSTO = 10'h010;
    localparam logic [9:0] CSR  = 10'h008;
    localparam logic [9:0] ITK  = 10'h004;
    localparam logic [9:0] MRET = 10'h002;
    localparam logic [9:0] ILL  = 10'h001;

    logic CLK;
    logic RST;
    int   n_vec;
    int   n_miss;

    cu_fsm_irq_if #(.NUM_INT(4)) ia ();
    cu_fsm_irq_if #(.NUM_INT(1)) ib ();

    cu_fsm_irq #(.NUM_INT(4), .FETCH_LAT(1), .LOAD_LAT(1)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (ia)
    );

    cu_fsm_irq #(.NUM_INT(1), .FETCH_LAT(3), .LOAD_LAT(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (ib)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [9:0] ctl_a, ctl_b;
    assign ctl_a = {ia.PCWrite, ia.regWrite, ia.memWE2, ia.memRDEN1, ia.memRDEN2,
                    ia.reset, ia.csr_WE, ia.int_taken, ia.mret_exec, ia.illegal};
    assign ctl_b = {ib.PCWrite, ib.regWrite, ib.memWE2, ib.memRDEN1, ib.memRDEN2,
                    ib.reset, ib.csr_WE, ib.int_taken, ib.mret_exec, ib.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Settle combinational outputs, then compare both DUTs ({controls, int_id}).
    task automatic step(input string tag, input logic [9:0] ea, input int ida,
                        input logic [9:0] eb, input int idb);
        logic [1:0] xa, xb;
        xa = 2'(ida);
        xb = 2'(idb);
        #1;
        chk({tag, "_a"}, {20'd0, ctl_a, ia.int_id}, {20'd0, ea, xa});
        chk({tag, "_b"}, {20'd0, ctl_b, 1'b0, ib.int_id}, {20'd0, eb, xb});
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        RST        = 1'b1;
        ia.ir6_0   = 7'b0110011;
        ia.ir14_12 = 3'b000;
        ia.intr    = 4'b0000;
        ia.int_en  = 1'b0;
        ib.ir6_0   = 7'b0000011;
        ib.ir14_12 = 3'b010;
        ib.intr    = 1'b0;
        ib.int_en  = 1'b0;

        @(negedge CLK); step("reset",   RSTO, 0, RSTO, 0); RST = 1'b0;
        @(negedge CLK); step("r_f1",    RD1, 0, RD1, 0);
        @(negedge CLK); step("r_ex1",   PCW | RW, 0, RD1, 0);
        @(negedge CLK); step("r_f2",    RD1, 0, RD1, 0);
        @(negedge CLK); step("r_ex2",   PCW | RW, 0, RD2, 0);
        @(negedge CLK); ia.ir6_0 = 7'b0100011;
                        step("st_f",    RD1, 0, RD2, 0);
        @(negedge CLK); step("st_ex",   PCW | WE2, 0, PCW | RW, 0);
        RST = 1'b1;     step("arst",    RSTO, 0, RSTO, 0);
        @(negedge CLK); step("init",    RSTO, 0, RSTO, 0); RST = 1'b0;
        @(negedge CLK); ia.ir6_0 = 7'b1110011; ia.ir14_12 = 3'b001;
                        step("csr_f",   RD1, 0, RD1, 0);
        @(negedge CLK); step("csr_ex",  CSR | RW | PCW, 0, RD1, 0);
        @(negedge CLK); ia.ir14_12 = 3'b000;
                        step("mret_f",  RD1, 0, RD1, 0);
        @(negedge CLK); step("mret_ex", MRET | PCW, 0, RD2, 0);
        @(negedge CLK); ia.ir6_0 = 7'b0110011; ia.intr = 4'b1010; ia.int_en = 1'b1;
                        ib.intr = 1'b1; ib.int_en = 1'b1;
                        step("irq_f",   RD1, 0, RD2, 0);
        @(negedge CLK); step("irq_ex",  PCW | RW, 0, PCW | RW, 0);
        @(negedge CLK); step("irq_ent", ITK | PCW, 1, ITK | PCW, 0);
        @(negedge CLK); ia.int_en = 1'b0; ib.intr = 1'b0;
                        step("msk_f1",  RD1, 0, RD1, 0);
        @(negedge CLK); step("msk_ex",  PCW | RW, 0, RD1, 0);
        @(negedge CLK); step("msk_f2",  RD1, 0, RD1, 0);
        @(negedge CLK); ia.ir6_0 = 7'b1111111; ia.intr = 4'b0000; ia.int_en = 1'b1;
                        step("ill_ex",  ILL | PCW, 0, RD2, 0);
        @(negedge CLK); step("ill_nx",  RD1, 0, RD2, 0);
        @(negedge CLK); ia.ir6_0 = 7'b0110011; ia.intr = 4'b1100;
                        step("pri_ex",  PCW | RW, 0, PCW | RW, 0);
        @(negedge CLK); ia.intr = 4'b1000;
                        step("pri_ent", ITK | PCW, 3, RD1, 0);
        @(negedge CLK); ia.intr = 4'b0000;
                        step("ld_f",    RD1, 0, RD1, 0);
        @(negedge CLK); ia.ir6_0 = 7'b0000011;
                        step("ld_ex",   RD2, 0, RD1, 0);
        @(negedge CLK); ia.intr = 4'b0001;
                        step("ld_wb",   PCW | RW, 0, RD2, 0);
        @(negedge CLK); ia.intr = 4'b0000;
                        step("drop",    ITK | PCW, 0, RD2, 0);
        @(negedge CLK); step("post",    RD1, 0, PCW | RW, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
